mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single CPU data port of the memory map between two requesters: M0 (CPU load/store unit) and M1 (DMA/scroll engine).
//  Grants at most one access per cycle, supports locked bursts, and returns read data to the issuing master after READ_LAT cycles.
//  Sits between the masters and the memory map's cpu_addr/cpu_wrdata/cpu_memop/cpu_we/cpu_rddata port.
// PARAMETERS
//  READ_LAT  1   cycles from accepted read to valid data on mem_rddata (registered dram/tmp_stack read); legal 1..4
//  LOCK_MAX  8   max consecutive grants to a locked owner before forced release; legal 1..255
//  MAX_WAIT  4   M1 wait-cycle threshold for aging (only with ARB_AGING_EN); legal 1..255
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  m0_req       in   1   M0 access request, held until m0_gnt
//  m0_lock      in   1   M0 requests ownership after this grant
//  m0_addr      in   32  M0 byte address
//  m0_wrdata    in   32  M0 write data
//  m0_we        in   1   M0 write (1) / read (0)
//  m0_memop     in   3   M0 size/sign code, passed through unchanged
//  m0_gnt       out  1   M0 access issued this cycle
//  m0_rvalid    out  1   M0 read data valid on m0_rddata
//  m0_rddata    out  32  read data to M0
//  m1_*         same set as m0_* for M1
//  mem_addr     out  32  to memory map cpu_addr
//  mem_wrdata   out  32  to memory map cpu_wrdata
//  mem_memop    out  3   to memory map cpu_memop
//  mem_we       out  1   to memory map cpu_we
//  mem_rddata   in   32  from memory map cpu_rddata
// BEHAVIOUR
//  - Reset: state IDLE, lock count 0, age count 0, read tag pipe cleared; mN_gnt, mN_rvalid, mem_we = 0; mem_addr/wrdata/memop = 0.
//  - Reset mid-operation: in-flight reads dropped; no rvalid is ever produced for them.
//  - Grant is combinational within the cycle: winner's addr/wrdata/we/memop drive mem_*; with no winner mem_we=0 and mem_* = 0.
//  - A grant means the access is issued that cycle; the master may change its request on the next edge.
//  - States: IDLE, OWN_M0, OWN_M1.
//    IDLE: M0 wins if m0_req; else M1 if m1_req (strict priority). Winner with lock=1 -> OWN_Mx, lock count = 1.
//    OWN_Mx: only Mx can be granted; other master's gnt forced 0 even if Mx idle.
//      Mx granted with lock=0 -> IDLE. Mx req=0 and lock=0 -> IDLE (no grant).
//      Mx granted with lock=1: lock count increments; when lock count reaches LOCK_MAX on a grant -> IDLE, next cycle arbitrates normally.
//  - Read tag pipe: READ_LAT-deep shift register of {valid, owner}; pushes {1, winner} on granted read, {0, x} otherwise.
//  - Read return: mN_rvalid = 1 exactly READ_LAT cycles after an accepted read, only for the owner.
//  - Read data: mN_rddata = mem_rddata unregistered; value is meaningful only when mN_rvalid = 1.
//  - Writes produce no rvalid. Back-to-back reads from alternating masters each return in order, one per cycle.
//  - Simultaneous m0_req and m1_req in IDLE: M0 wins (unless aging overrides, see below).
//  - Lock count is 8-bit and saturates at LOCK_MAX; no wrap.
// CONFIGURATION
//  ARB_AGING_EN defined:
//    8-bit age counter increments each cycle m1_req=1 and m1_gnt=0, and clears on m1_gnt.
//    When the counter equals MAX_WAIT in IDLE, M1 wins over M0 for one grant.
//    Aging never preempts OWN_M0.
//  ARB_AGING_EN undefined: no age counter; strict M0 priority; M1 can starve indefinitely.
// TESTING
//  1. M1 read 0x00100010, M0 idle -> m1_gnt=1 same cycle, mem_addr=0x00100010, mem_we=0; next cycle m1_rvalid=1 with mem_rddata, m0_rvalid=0.
//  2. M0 and M1 req for 10 cycles, macro off -> m0_gnt=1 every cycle, m1_gnt=0; m1_gnt=1 in the first cycle after M0 drops req.
//  3. M1 locked burst of 4 writes to 0x00300000..0x0030000C, lock=0 on the 4th; M0 req throughout -> m0_gnt=0 for 4 cycles, then m0_gnt=1.
//  4. LOCK_MAX=8, M1 holds lock and req for 20 cycles, M0 req -> M1 granted 8 cycles, M0 granted cycle 9.
//  5. ARB_AGING_EN, MAX_WAIT=4, M0 and M1 req continuously -> M1 granted on cycle 5 for one cycle, then M0; pattern repeats every 5 cycles.
//  6. rst_n low one cycle after granted M0 read (READ_LAT=2) -> m0_rvalid stays 0 after release, state IDLE, all gnt=0 during reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// One requester channel of the memory-port arbiter: request/bus signals from a
// master plus grant and read-return signals back to it.
interface mem_port_arbiter_if;
  logic        req;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wrdata;
  logic        we;
  logic [2:0]  memop;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rddata;

  modport master (
    output req, lock, addr, wrdata, we, memop,
    input  gnt, rvalid, rddata
  );

  modport slave (
    input  req, lock, addr, wrdata, we, memop,
    output gnt, rvalid, rddata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the CPU data port of the memory map, with locked bursts
// and tagged read return. Optional M1 aging is enabled by defining ARB_AGING_EN.
module mem_port_arbiter #(
  parameter int READ_LAT = 1,
  parameter int LOCK_MAX = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   m0,
  mem_port_arbiter_if.slave   m1,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wrdata,
  output logic [2:0]          mem_memop,
  output logic                mem_we,
  input  logic [31:0]         mem_rddata
);

  localparam logic [7:0] LOCK_C     = 8'(LOCK_MAX);
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

  state_t     state_reg, state_next;
  logic [7:0] lock_cnt_reg, lock_cnt_next;
  logic [7:0] lock_inc;
  logic       gnt0, gnt1;
  logic       own_req, own_lock;
  logic       age_hit;

`ifdef ARB_AGING_EN
  logic [7:0] age_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_reg <= 8'd0;
    end else if (gnt1) begin
      age_reg <= 8'd0;
    end else if (m1.req && age_reg != 8'hFF) begin
      age_reg <= age_reg + 8'd1;
    end
  end

  assign age_hit = (age_reg == MAX_WAIT_C);
`else
  logic [7:0] unused_max_wait;
  assign unused_max_wait = MAX_WAIT_C;
  assign age_hit         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lock_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  assign lock_inc = lock_cnt_reg + 8'd1;

  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    own_req       = (state_reg == OWN_M1) ? m1.req  : m0.req;
    own_lock      = (state_reg == OWN_M1) ? m1.lock : m0.lock;
    case (state_reg)
      IDLE: begin
        lock_cnt_next = 8'd0;
        if (m1.req && (!m0.req || age_hit)) begin
          gnt1 = 1'b1;
          if (m1.lock) begin
            lock_cnt_next = 8'd1;
            state_next    = (LOCK_C == 8'd1) ? IDLE : OWN_M1;
          end
        end else if (m0.req) begin
          gnt0 = 1'b1;
          if (m0.lock) begin
            lock_cnt_next = 8'd1;
            state_next    = (LOCK_C == 8'd1) ? IDLE : OWN_M0;
          end
        end
      end
      OWN_M0, OWN_M1: begin
        // The non-owner is never granted here, even while the owner is idle.
        if (own_req) begin
          gnt0 = (state_reg == OWN_M0);
          gnt1 = (state_reg == OWN_M1);
          if (own_lock) begin
            lock_cnt_next = lock_inc;
            if (lock_inc >= LOCK_C) begin
              state_next = IDLE;
            end
          end else begin
            lock_cnt_next = 8'd0;
            state_next    = IDLE;
          end
        end else if (!own_lock) begin
          lock_cnt_next = 8'd0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next    = IDLE;
        lock_cnt_next = 8'd0;
      end
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  always_comb begin
    mem_addr   = 32'd0;
    mem_wrdata = 32'd0;
    mem_memop  = 3'd0;
    mem_we     = 1'b0;
    if (gnt0) begin
      mem_addr   = m0.addr;
      mem_wrdata = m0.wrdata;
      mem_memop  = m0.memop;
      mem_we     = m0.we;
    end else if (gnt1) begin
      mem_addr   = m1.addr;
      mem_wrdata = m1.wrdata;
      mem_memop  = m1.memop;
      mem_we     = m1.we;
    end
  end

  // Read tag pipe: bit 0 is the newest issue, bit READ_LAT-1 lines up with mem_rddata.
  logic [READ_LAT-1:0] tag_valid_reg, tag_valid_next;
  logic [READ_LAT-1:0] tag_owner_reg, tag_owner_next;

  assign tag_valid_next[0] = (gnt0 && !m0.we) || (gnt1 && !m1.we);
  assign tag_owner_next[0] = gnt1;

  generate
    for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_tag_stage
      assign tag_valid_next[gi] = tag_valid_reg[gi-1];
      assign tag_owner_next[gi] = tag_owner_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_reg <= '0;
      tag_owner_reg <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_owner_reg <= tag_owner_next;
    end
  end

  assign m0.rvalid = tag_valid_reg[READ_LAT-1] && !tag_owner_reg[READ_LAT-1];
  assign m1.rvalid = tag_valid_reg[READ_LAT-1] &&  tag_owner_reg[READ_LAT-1];
  assign m0.rddata = mem_rddata;
  assign m1.rddata = mem_rddata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario-driven bench for mem_port_arbiter; read returns are checked against a
// queue of expected {due cycle, master} entries pushed when each read is issued.
module tb_mem_port_arbiter;
  localparam int RL = 2;
  localparam int LM = 8;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_addr, mem_wrdata, mem_rddata;
  logic [2:0]  mem_memop;
  logic        mem_we;
  logic [31:0] cyc = 32'd0;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] due;
    bit          master;
  } exp_t;
  exp_t exp_q[$];

  mem_port_arbiter_if m0_if();
  mem_port_arbiter_if m1_if();

  mem_port_arbiter #(.READ_LAT(RL), .LOCK_MAX(LM), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_memop(mem_memop),
    .mem_we(mem_we), .mem_rddata(mem_rddata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign mem_rddata = 32'hA500_0000 ^ cyc;

  // Read-return monitor: compares rvalid/rddata every cycle against the queue head.
  always @(negedge clk) begin
    logic e0, e1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (exp_q[0].master) e1 = 1'b1; else e0 = 1'b1;
        void'(exp_q.pop_front());
      end
      n_checks++;
      if (m0_if.rvalid !== e0 || m1_if.rvalid !== e1) begin
        n_fail++;
        $display("FAIL rvalid cyc=%0d got m0=%b m1=%b expected m0=%b m1=%b",
                 cyc, m0_if.rvalid, m1_if.rvalid, e0, e1);
      end
      if (e0 || e1) begin
        n_checks++;
        if ((e0 ? m0_if.rddata : m1_if.rddata) !== (32'hA500_0000 ^ cyc)) begin
          n_fail++;
          $display("FAIL rddata cyc=%0d got %h expected %h",
                   cyc, e0 ? m0_if.rddata : m1_if.rddata, 32'hA500_0000 ^ cyc);
        end else begin
          $display("read return m%0d cyc=%0d data=%h", e1, cyc, 32'hA500_0000 ^ cyc);
        end
      end
    end
  end

  task automatic drive(input bit idx, input logic req, input logic lock, input logic we,
                       input logic [31:0] addr, input logic [31:0] wrdata,
                       input logic [2:0] memop);
    if (idx == 1'b0) begin
      m0_if.req = req; m0_if.lock = lock; m0_if.we = we;
      m0_if.addr = addr; m0_if.wrdata = wrdata; m0_if.memop = memop;
    end else begin
      m1_if.req = req; m1_if.lock = lock; m1_if.we = we;
      m1_if.addr = addr; m1_if.wrdata = wrdata; m1_if.memop = memop;
    end
  endtask

  task automatic idle_both();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h55, 3'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h5678, 32'h0, 3'd1);
    exp_q.delete();
    #1;
    n_checks++;
    if (m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt got m0=%b m1=%b expected 0 0", m0_if.gnt, m1_if.gnt);
    end
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wrdata !== 32'd0 || mem_memop !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_bus got we=%b addr=%h wd=%h op=%h expected all 0",
               mem_we, mem_addr, mem_wrdata, mem_memop);
    end
    n_checks++;
    if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid got m0=%b m1=%b expected 0 0", m0_if.rvalid, m1_if.rvalid);
    end
    mon_en = 1'b1;
    @(negedge clk);
    idle_both();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0010_0010, 32'd0, 3'b010);
    #1;
    n_checks++;
    if (m1_if.gnt !== 1'b1 || m0_if.gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gnt got m0=%b m1=%b expected 0 1", m0_if.gnt, m1_if.gnt);
    end
    n_checks++;
    if (mem_addr !== 32'h0010_0010 || mem_we !== 1'b0 || mem_memop !== 3'b010) begin
      n_fail++;
      $display("FAIL single_bus got addr=%h we=%b op=%h expected 00100010 0 2",
               mem_addr, mem_we, mem_memop);
    end
    exp_q.push_back('{due: cyc + RL, master: 1'b1});
    $display("issue m1 read addr=00100010 cyc=%0d", cyc);
    @(negedge clk);
    idle_both();
    repeat (RL + 1) @(negedge clk);
  endtask

  task automatic test_priority();
    for (int k = 0; k < 11; k++) begin
      bit exp1;
      @(negedge clk);
      drive(1'b0, (k < 10), 1'b0, 1'b0, 32'h1000 + 32'(k * 4), 32'd0, 3'd2);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h2000, 32'hCAFE_0000 + 32'(k), 3'd2);
`ifdef ARB_AGING_EN
      exp1 = (k == 10) || (k % 5 == 4);
`else
      exp1 = (k == 10);
`endif
      #1;
      n_checks++;
      if (m0_if.gnt !== !exp1 || m1_if.gnt !== exp1) begin
        n_fail++;
        $display("FAIL priority_gnt k=%0d got m0=%b m1=%b expected %b %b",
                 k, m0_if.gnt, m1_if.gnt, !exp1, exp1);
      end
      n_checks++;
      if (mem_addr !== (exp1 ? 32'h2000 : 32'h1000 + 32'(k * 4)) || mem_we !== exp1) begin
        n_fail++;
        $display("FAIL priority_bus k=%0d got addr=%h we=%b", k, mem_addr, mem_we);
      end
      if (!exp1) exp_q.push_back('{due: cyc + RL, master: 1'b0});
    end
    @(negedge clk);
    idle_both();
    repeat (RL + 1) @(negedge clk);
  endtask

  task automatic test_locked_burst();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, (k > 0), 1'b0, 1'b0, 32'h40, 32'd0, 3'd2);
      drive(1'b1, (k < 4), (k < 3), 1'b1, 32'h0030_0000 + 32'(k * 4), 32'hD0 + 32'(k), 3'd2);
      #1;
      n_checks++;
      if (m1_if.gnt !== (k < 4) || m0_if.gnt !== (k == 4)) begin
        n_fail++;
        $display("FAIL burst_gnt k=%0d got m0=%b m1=%b expected %b %b",
                 k, m0_if.gnt, m1_if.gnt, (k == 4), (k < 4));
      end
      if (k < 4) begin
        n_checks++;
        if (mem_addr !== 32'h0030_0000 + 32'(k * 4) || mem_we !== 1'b1 ||
            mem_wrdata !== 32'hD0 + 32'(k)) begin
          n_fail++;
          $display("FAIL burst_bus k=%0d got addr=%h we=%b wd=%h", k, mem_addr, mem_we, mem_wrdata);
        end
      end else begin
        exp_q.push_back('{due: cyc + RL, master: 1'b0});
      end
    end
    @(negedge clk);
    idle_both();
    repeat (RL + 1) @(negedge clk);
  endtask

  task automatic test_lock_max();
    for (int k = 0; k < 10; k++) begin
      bit exp0;
      @(negedge clk);
      drive(1'b0, (k > 0), 1'b0, 1'b0, 32'h80, 32'd0, 3'd2);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0030_0100, 32'hBEEF, 3'd2);
      exp0 = (k >= LM);
      #1;
      n_checks++;
      if (m0_if.gnt !== exp0 || m1_if.gnt !== !exp0) begin
        n_fail++;
        $display("FAIL lockmax_gnt k=%0d got m0=%b m1=%b expected %b %b",
                 k, m0_if.gnt, m1_if.gnt, exp0, !exp0);
      end
      if (exp0) exp_q.push_back('{due: cyc + RL, master: 1'b0});
    end
    @(negedge clk);
    idle_both();
    repeat (RL + 1) @(negedge clk);
    // Owner holds lock but stops requesting: the other master must still be held off.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, (k > 0), 1'b0, 1'b1, 32'h90, 32'h9, 3'd2);
      drive(1'b1, (k == 0), (k < 2), 1'b1, 32'h0030_0200, 32'h1, 3'd2);
      #1;
      n_checks++;
      if (m0_if.gnt !== (k == 3) || m1_if.gnt !== (k == 0)) begin
        n_fail++;
        $display("FAIL own_idle k=%0d got m0=%b m1=%b expected %b %b",
                 k, m0_if.gnt, m1_if.gnt, (k == 3), (k == 0));
      end
      if (k == 1 || k == 2) begin
        n_checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'd0) begin
          n_fail++;
          $display("FAIL own_idle_bus k=%0d got we=%b addr=%h expected 0 0", k, mem_we, mem_addr);
        end
      end
    end
    @(negedge clk);
    idle_both();
    repeat (RL + 1) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'd0, 3'd2);
    #1;
    n_checks++;
    if (m0_if.gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_gnt got %b expected 1", m0_if.gnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'd0, 3'd2);
    #1;
    n_checks++;
    if (m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_rst_gnt got m0=%b m1=%b expected 0 0", m0_if.gnt, m1_if.gnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_both();
    repeat (RL + 1) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 32'h7, 3'd2);
    #1;
    n_checks++;
    if (m1_if.gnt !== 1'b1 || m0_if.gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_idle got m0=%b m1=%b expected 0 1", m0_if.gnt, m1_if.gnt);
    end
    @(negedge clk);
    idle_both();
    repeat (RL + 2) @(negedge clk);
  endtask

  initial begin
    idle_both();
    test_reset();
    test_single_read();
    test_priority();
    test_locked_burst();
    test_lock_max();
    test_reset_inflight();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
